divu_iter: RTL and testbench

- Parametrised iterative radix-2 restoring divider; successor to the fixed 256-bit unsigned divider.
- Adds a WIDTH parameter, explicit start/busy/done handshake and a per-operation signed mode (RISC-V semantics).
- Also defines divide-by-zero and overflow results.
- Sits beside the ALU as a multi-cycle functional unit; one operation in flight at a time.

---
 rtl/divu_pkg.sv | 22 ++
 rtl/divu_step.sv | 29 ++
 rtl/divu_iter.sv | 164 ++++++++++++++++
 tb/tb_divu_iter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/divu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divu_pkg
// Purpose  : Shared state encoding and sizing helper for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package divu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    // Iteration counter width; at least one bit even for the smallest divider.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/divu_step.sv
`default_nettype none
// ============================================================================
// Module   : divu_step
// Purpose  : One restoring-division step: shift in a dividend bit, trial subtract.
// Revision : 1.0 - initial release
// ============================================================================
module divu_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    assign w_trial = {i_rem, i_bit};
    assign w_diff  = w_trial - {1'b0, i_dvs};

    // With i_rem < i_dvs the difference never exceeds WIDTH bits when it is
    // non-negative, so its top bit is exactly the borrow.
    assign o_qbit = ~w_diff[WIDTH];
    assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/divu_iter.sv
`default_nettype none
// ============================================================================
// Module   : divu_iter
// Purpose  : Iterative radix-2 restoring divider, unsigned or signed per operation.
// Revision : 1.0 - initial release
// ============================================================================
module divu_iter
    import divu_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] divd,
    input  logic [WIDTH-1:0] dvsr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dbz,
    output logic [1:0]       state
);

    localparam int             CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dbzp_q, dbzp_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             w_sgn;
    logic [WIDTH-1:0] w_divd_mag;
    logic [WIDTH-1:0] w_dvsr_mag;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;

    assign w_sgn      = signed_op & SIGNED_EN;
    assign w_divd_mag = (w_sgn && divd[WIDTH-1]) ? ('0 - divd) : divd;
    assign w_dvsr_mag = (w_sgn && dvsr[WIDTH-1]) ? ('0 - dvsr) : dvsr;

    divu_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_q),
        .i_bit  (dvd_q[WIDTH-1]),
        .i_dvs  (dvs_q),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_q)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbzp_d  = dbzp_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    qneg_d = w_sgn & (divd[WIDTH-1] ^ dvsr[WIDTH-1]);
                    rneg_d = w_sgn & divd[WIDTH-1];
                    r_d    = '0;
                    cnt_d  = '0;
                    dvs_d  = w_dvsr_mag;
                    if (dvsr == '0) begin
                        // Keep the raw dividend: it is returned verbatim as rem.
                        dbzp_d  = 1'b1;
                        dvd_d   = divd;
                        state_d = FIXUP;
                    end else begin
                        dbzp_d  = 1'b0;
                        dvd_d   = w_divd_mag;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // Dividend shifts out MSB first; quotient bits fill in from the LSB.
                r_d   = w_step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], w_step_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == C_LAST) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                if (dbzp_q) begin
                    quo_d = '1;
                    rem_d = dvd_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = qneg_q ? ('0 - dvd_q) : dvd_q;
                    rem_d = rneg_q ? ('0 - r_q) : r_q;
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbzp_q  <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbzp_q  <= dbzp_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign quo   = quo_q;
    assign rem   = rem_q;
    assign dbz   = dbz_q;
    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_divu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_divu_iter
// Purpose  : Scoreboard bench for divu_iter at WIDTH=8 and WIDTH=256.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divu_iter;

    typedef struct {
        logic [255:0] quo;
        logic [255:0] rem;
        logic         dbz;
        int           e0;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    logic         start8 = 1'b0, sop8 = 1'b0;
    logic [7:0]   divd8 = '0, dvsr8 = '0;
    logic         busy8, done8, dbz8;
    logic [7:0]   quo8, rem8;
    logic [1:0]   state8;

    logic         start256 = 1'b0, sop256 = 1'b0;
    logic [255:0] divd256 = '0, dvsr256 = '0;
    logic         busy256, done256, dbz256;
    logic [255:0] quo256, rem256;
    logic [1:0]   state256;

    exp_t q8[$];
    exp_t q256[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divu_iter #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_op(sop8),
        .divd(divd8), .dvsr(dvsr8), .busy(busy8), .done(done8),
        .quo(quo8), .rem(rem8), .dbz(dbz8), .state(state8)
    );

    divu_iter #(.WIDTH(256), .SIGNED_EN(1'b1)) u_dut256 (
        .clk(clk), .rst(rst), .start(start256), .signed_op(sop256),
        .divd(divd256), .dvsr(dvsr256), .busy(busy256), .done(done256),
        .quo(quo256), .rem(rem256), .dbz(dbz256), .state(state256)
    );

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitors: pop one expected result per done pulse.
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 256'(done8), 256'(0));
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("quo8", 256'(quo8), e.quo);
                chk("rem8", 256'(rem8), e.rem);
                chk("dbz8", 256'(dbz8), 256'(e.dbz));
                chk("lat8", 256'(cyc - e.e0), 256'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done256) begin
            if (q256.size() == 0) begin
                chk("done256_unexpected", 256'(done256), 256'(0));
            end else begin
                exp_t e;
                e = q256.pop_front();
                chk("quo256", quo256, e.quo);
                chk("rem256", rem256, e.rem);
                chk("dbz256", 256'(dbz256), 256'(e.dbz));
                chk("lat256", 256'(cyc - e.e0), 256'(e.lat));
            end
        end
    end

    // Called at a negedge; start is seen at the next rising edge (E0).
    task automatic issue8(input logic sop, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ed);
        exp_t e;
        start8 = 1'b1; sop8 = sop; divd8 = a; dvsr8 = b;
        e.quo = 256'(eq); e.rem = 256'(er); e.dbz = ed;
        e.e0 = cyc + 1; e.lat = ed ? 1 : 9;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0; sop8 = ~sop; divd8 = 8'hA5; dvsr8 = 8'h3C;
    endtask

    task automatic issue256(input logic [255:0] a, input logic [255:0] b,
                            input logic [255:0] eq, input logic [255:0] er);
        exp_t e;
        start256 = 1'b1; sop256 = 1'b0; divd256 = a; dvsr256 = b;
        e.quo = eq; e.rem = er; e.dbz = 1'b0;
        e.e0 = cyc + 1; e.lat = 257;
        q256.push_back(e);
        @(negedge clk);
        start256 = 1'b0; divd256 = '0; dvsr256 = 256'd3;
    endtask

    task automatic wait_idle8();
        int n = 0;
        while ((busy8 || q8.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle8_timeout", 256'(n < 100), 256'(1));
    endtask

    task automatic wait_idle256();
        int n = 0;
        while ((busy256 || q256.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle256_timeout", 256'(n < 1000), 256'(1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state8", 256'(state8), 256'(0));
        chk("rst_busy8",  256'(busy8),  256'(0));
        chk("rst_done8",  256'(done8),  256'(0));
        chk("rst_quo8",   256'(quo8),   256'(0));
        chk("rst_rem8",   256'(rem8),   256'(0));
        chk("rst_dbz8",   256'(dbz8),   256'(0));
        chk("rst_busy256", 256'(busy256), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // Unsigned basics and divide-by-zero
        issue8(1'b0, 8'd12,  8'd5, 8'd2,   8'd2,   1'b0); wait_idle8();
        issue8(1'b0, 8'd250, 8'd3, 8'd83,  8'd1,   1'b0); wait_idle8();
        issue8(1'b0, 8'd100, 8'd0, 8'hFF,  8'd100, 1'b1); wait_idle8();
        issue8(1'b1, 8'd100, 8'd0, 8'hFF,  8'd100, 1'b1); wait_idle8();
        issue8(1'b1, 8'hFB,  8'd0, 8'hFF,  8'hFB,  1'b1); wait_idle8();

        // Signed: truncation toward zero, remainder follows dividend, overflow
        issue8(1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0); wait_idle8();
        issue8(1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0); wait_idle8();
        issue8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0); wait_idle8();
        issue8(1'b0, 8'hF9, 8'h02, 8'h7C, 8'h01, 1'b0); wait_idle8();

        // Start while busy is ignored
        issue8(1'b0, 8'd45, 8'd9, 8'd5, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        start8 = 1'b1; sop8 = 1'b1; divd8 = 8'd1; dvsr8 = 8'd9;
        @(negedge clk);
        start8 = 1'b0;
        begin
            int n = 0;
            while (state8 != 2'd3 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("done_state_timeout", 256'(n < 50), 256'(1));
        end
        // Held through DONE (ignored) and into IDLE (accepted)
        begin
            exp_t e;
            start8 = 1'b1; sop8 = 1'b0; divd8 = 8'd200; dvsr8 = 8'd7;
            e.quo = 256'd28; e.rem = 256'd4; e.dbz = 1'b0;
            e.e0 = cyc + 2; e.lat = 9;
            q8.push_back(e);
            repeat (2) @(negedge clk);
            start8 = 1'b0;
        end
        wait_idle8();

        // Wide unsigned
        issue256('1, '1, 256'd1, 256'd0); wait_idle256();
        issue256(256'd5, 256'd7, 256'd0, 256'd5); wait_idle256();

        // Asynchronous reset mid-CALC
        issue8(1'b0, 8'd45, 8'd9, 8'd5, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_state8", 256'(state8), 256'(0));
        chk("arst_busy8",  256'(busy8),  256'(0));
        chk("arst_quo8",   256'(quo8),   256'(0));
        chk("arst_rem8",   256'(rem8),   256'(0));
        q8.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue8(1'b0, 8'd45, 8'd9, 8'd5, 8'd0, 1'b0); wait_idle8();

        chk("q8_empty",   256'(q8.size()),   256'(0));
        chk("q256_empty", 256'(q256.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
